// File: rtl/fsk_modulator.sv
// Byte-wide FSK square-wave modulator: LSB-first bits, continuous-phase tones,
// optional alternating preamble enabled by defining FSK_MODULATOR_PREAMBLE_EN.
module fsk_modulator #(
  parameter int FREQUENCY0           = 9000,
  parameter int FREQUENCY1           = 11000,
  parameter int CLOCK_FREQUENCY      = 50000000,
  parameter int HALF_PERIODS_PER_BIT = 8,
  parameter int PREAMBLE_BITS        = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sample_out,
  output logic        busy,
  output logic        bit_strobe,
  output logic        frame_done,
  output logic [31:0] bytes_sent
);

  localparam logic [31:0] TICKS0 = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY0));
  localparam logic [31:0] TICKS1 = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY1));
  localparam int HALF_W = $clog2(HALF_PERIODS_PER_BIT);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PERIODS_PER_BIT - 1);

  // An odd half-period count would leave the line high between frames.
  if (FREQUENCY1 <= FREQUENCY0 || TICKS0 < 32'd2 || TICKS1 < 32'd2 ||
      HALF_PERIODS_PER_BIT < 2 || (HALF_PERIODS_PER_BIT % 2) != 0 ||
      PREAMBLE_BITS < 1) begin : g_bad_params
    $error("fsk_modulator: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    PREAMBLE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       tick_q, tick_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic [31:0]       count_q, count_d;
  logic              cur_bit;
  logic [31:0]       tick_last;

`ifdef FSK_MODULATOR_PREAMBLE_EN
  localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);
  logic [PRE_W-1:0]  pre_q, pre_d;
`endif

  // NOTE: every signal gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    half_d    = half_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    busy_d    = busy_q;
    strobe_d  = strobe_q;
    done_d    = done_q;
    count_d   = count_q;
`ifdef FSK_MODULATOR_PREAMBLE_EN
    pre_d     = pre_q;
`endif

    case (state_q)
      DATA:     cur_bit = shift_q[0];
`ifdef FSK_MODULATOR_PREAMBLE_EN
      PREAMBLE: cur_bit = ~pre_q[0];
`endif
      default:  cur_bit = 1'b0;
    endcase
    tick_last = cur_bit ? (TICKS1 - 32'd1) : (TICKS0 - 32'd1);

    // With enable low everything, including pending pulses, simply holds.
    if (enable) begin
      strobe_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_d   = tx_data;
            tick_d    = '0;
            half_d    = '0;
            bit_idx_d = '0;
            sample_d  = 1'b0;
            busy_d    = 1'b1;
`ifdef FSK_MODULATOR_PREAMBLE_EN
            pre_d     = '0;
            state_d   = PREAMBLE;
`else
            state_d   = DATA;
`endif
          end
        end
        default: begin
          if (tick_q == tick_last) begin
            tick_d   = '0;
            sample_d = ~sample_q;
            if (half_q == HALF_LAST) begin
              half_d   = '0;
              strobe_d = 1'b1;
              if (state_q == DATA) begin
                shift_d = {1'b0, shift_q[7:1]};
                if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  count_d   = count_q + 32'd1;
                end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                end
              end
`ifdef FSK_MODULATOR_PREAMBLE_EN
              else if (pre_q == PRE_LAST) begin
                pre_d   = '0;
                state_d = DATA;
              end else begin
                pre_d = pre_q + 1'b1;
              end
`endif
            end else begin
              half_d = half_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      half_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
`ifdef FSK_MODULATOR_PREAMBLE_EN
      pre_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      half_q    <= half_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      count_q   <= count_d;
`ifdef FSK_MODULATOR_PREAMBLE_EN
      pre_q     <= pre_d;
`endif
    end
  end

  assign tx_ready   = enable && (state_q == IDLE);
  assign sample_out = sample_q;
  assign busy       = busy_q;
  assign bit_strobe = strobe_q && enable;
  assign frame_done = done_q && enable;
  assign bytes_sent = count_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator: directed frames plus random bytes,
// stalls and back-to-back chains compared against a toggle-time model.
module tb_fsk_modulator;

  localparam int CLK_HZ   = 1000;
  localparam int F0       = 50;
  localparam int F1       = 100;
  localparam int HPB      = 4;
  localparam int PRE_BITS = 4;
  localparam int T0       = CLK_HZ / (2 * F0);
  localparam int T1       = CLK_HZ / (2 * F1);
`ifdef FSK_MODULATOR_PREAMBLE_EN
  localparam int PRE_N    = PRE_BITS;
  localparam int PRE_CYC  = 120;
`else
  localparam int PRE_N    = 0;
  localparam int PRE_CYC  = 0;
`endif
  localparam int LIMIT    = 3000;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, sample_out, busy, bit_strobe, frame_done;
  logic [31:0] bytes_sent;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bytes = 0;
  int toggle_q[$];
  int end_q[$];
  int total;

  always #5 clock = ~clock;

  fsk_modulator #(
    .FREQUENCY0(F0), .FREQUENCY1(F1), .CLOCK_FREQUENCY(CLK_HZ),
    .HALF_PERIODS_PER_BIT(HPB), .PREAMBLE_BITS(PRE_BITS)
  ) dut (
    .clock(clock), .clear(clear), .enable(enable), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .sample_out(sample_out),
    .busy(busy), .bit_strobe(bit_strobe), .frame_done(frame_done),
    .bytes_sent(bytes_sent)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Frame model: list of toggle instants and bit-end instants, in enabled
  // cycles after the accept edge.
  task automatic build_model(input logic [7:0] d);
    int base;
    int ticks;
    bit b;
    base = 0;
    toggle_q.delete();
    end_q.delete();
    for (int i = 0; i < PRE_N + 8; i++) begin
      if (i < PRE_N) b = ((i % 2) == 0);
      else           b = d[i - PRE_N];
      ticks = b ? T1 : T0;
      for (int h = 1; h <= HPB; h++) toggle_q.push_back(base + h * ticks);
      base += HPB * ticks;
      end_q.push_back(base);
    end
    total = base;
  endtask

  function automatic logic exp_sample(input int t);
    int n;
    n = 0;
    foreach (toggle_q[i]) if (toggle_q[i] <= t) n++;
    return logic'(n % 2);
  endfunction

  function automatic logic is_bit_end(input int t);
    foreach (end_q[i]) if (end_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic launch(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    check("ready_before_accept", tx_ready, 1);
  endtask

  // Runs one frame whose byte is already presented; returns wall-clock cycles
  // from accept to frame_done.
  task automatic run_frame(input logic [7:0] d, input int stall_at, input int stall_len,
                           input int abort_at, input bit junk, input bit chain,
                           input logic [7:0] next_d, output int wall);
    int t;
    int n_strobe;
    int n_done;
    build_model(d);
    t = 0;
    wall = 0;
    n_strobe = 0;
    @(posedge clock);
    forever begin
      @(negedge clock);
      check("sample_out", sample_out, exp_sample(t));
      check("bit_strobe", bit_strobe, enable && is_bit_end(t));
      check("frame_done", frame_done, enable && (t == total));
      check("busy", busy, t < total);
      check("tx_ready", tx_ready, enable && (t >= total));
      if (bit_strobe) n_strobe++;
      if (t == total) begin
        exp_bytes++;
        check("bytes_sent", bytes_sent, exp_bytes);
        check("strobe_count", n_strobe, PRE_N + 8);
        check("frame_cycles", wall, total + ((stall_at >= 0) ? stall_len : 0));
        if (chain) begin
          tx_data  = next_d;
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
        break;
      end
      if (wall >= LIMIT) begin
        check("frame_timeout", t, total);
        tx_valid = 1'b0;
        enable   = 1'b1;
        break;
      end
      if (wall == 0) begin
        if (junk) tx_data = ~d;
        else      tx_valid = 1'b0;
      end
      if (abort_at >= 0 && wall == abort_at) begin
        clear    = 1'b0;
        tx_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort_sample", sample_out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", tx_ready, 1);
        check("abort_bytes", bytes_sent, 0);
        check("abort_done", frame_done, 0);
        clear = 1'b1;
        exp_bytes = 0;
        n_done = 0;
        repeat (300) begin
          @(negedge clock);
          if (frame_done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        return;
      end
      if (wall == stall_at) enable = 1'b0;
      if (wall == stall_at + stall_len) enable = 1'b1;
      @(posedge clock);
      wall++;
      if (enable) t++;
    end
  endtask

  initial begin
    int w;
    int w_plain;
    logic [7:0] cur, nxt;
    bit ch;
    int sa, sl;

    clear  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_sample", sample_out, 0);
    check("rst_busy", busy, 0);
    check("rst_strobe", bit_strobe, 0);
    check("rst_done", frame_done, 0);
    check("rst_bytes", bytes_sent, 0);
    check("rst_ready", tx_ready, 1);
    clear  = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    check("ready_gated", tx_ready, 0);
    enable = 1'b1;
    @(negedge clock);

    launch(8'hA5);
    run_frame(8'hA5, -1, 0, -1, 1'b0, 1'b0, 8'h00, w);
    check("a5_cycles", w, 240 + PRE_CYC);
    check("a5_end_low", sample_out, 0);

    repeat (3) @(negedge clock);
    launch(8'h00);
    run_frame(8'h00, -1, 0, -1, 1'b0, 1'b1, 8'hFF, w);
    check("x00_cycles", w, 320 + PRE_CYC);
    run_frame(8'hFF, -1, 0, -1, 1'b0, 1'b0, 8'h00, w);
    check("xff_cycles", w, 160 + PRE_CYC);
    check("bytes_after_pair", bytes_sent, 3);

    repeat (2) @(negedge clock);
    launch(8'h0F);
    run_frame(8'h0F, -1, 0, -1, 1'b0, 1'b0, 8'h00, w_plain);
    repeat (2) @(negedge clock);
    launch(8'h0F);
    run_frame(8'h0F, 50, 37, -1, 1'b0, 1'b0, 8'h00, w);
    check("stall_delay", w - w_plain, 37);

    repeat (2) @(negedge clock);
    launch(8'h3C);
    run_frame(8'h3C, -1, 0, -1, 1'b1, 1'b0, 8'h00, w);

    repeat (2) @(negedge clock);
    launch(8'hA5);
    run_frame(8'hA5, -1, 0, 100, 1'b0, 1'b0, 8'h00, w);

    cur = 8'($urandom);
    launch(cur);
    for (int i = 0; i < 6; i++) begin
      nxt = 8'($urandom);
      ch  = (i < 5) && ($urandom_range(0, 1) == 1);
      sa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 150)) : -1;
      sl  = int'($urandom_range(1, 40));
      run_frame(cur, sa, sl, -1, 1'b0, ch, nxt, w);
      if (i < 5 && !ch) begin
        repeat (int'($urandom_range(1, 5))) @(negedge clock);
        launch(nxt);
      end
      cur = nxt;
    end
    check("bytes_final", bytes_sent, exp_bytes);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
